// File: rtl/mux2_stream_arbiter.sv
// Round-robin arbiter that steers a 2:1 valid/ready data mux between requesters A and B.
// Grants lock for a whole burst (until last or MAX_BURST beats); data passes through unregistered.
module mux2_stream_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] FINAL_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic LG_A = 1'b0;
    localparam logic LG_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] beat_cnt;

    logic cur_valid;
    logic cur_last;
    logic other_valid;
    logic xfer;
    logic release_grant;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cur_valid   = 1'b0;
        cur_last    = 1'b0;
        other_valid = 1'b0;
        case (state)
            GRANT_A: begin
                cur_valid   = a_valid;
                cur_last    = a_last;
                other_valid = b_valid;
            end
            GRANT_B: begin
                cur_valid   = b_valid;
                cur_last    = b_last;
                other_valid = a_valid;
            end
            default: ;
        endcase
    end

    assign xfer          = cur_valid & out_ready;
    // The MAX_BURST-th beat releases even without last, forcing re-arbitration.
    assign release_grant = xfer & (cur_last | (beat_cnt == FINAL_BEAT));

    assign a_ready   = (state == GRANT_A) & out_ready;
    assign b_ready   = (state == GRANT_B) & out_ready;
    assign out_valid = cur_valid;
    assign out_last  = cur_last;
    assign out_data  = sel ? b_data : a_data;
    assign busy      = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= LG_B;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (a_valid && (!b_valid || last_grant == LG_B)) begin
                        state <= GRANT_A;
                        sel   <= 1'b0;
                    end else if (b_valid) begin
                        state <= GRANT_B;
                        sel   <= 1'b1;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (release_grant) begin
                        last_grant <= (state == GRANT_B) ? LG_B : LG_A;
                        beat_cnt   <= '0;
                        // Hand straight to a waiting peer so no idle cycle separates bursts.
                        if (other_valid) begin
                            state <= (state == GRANT_A) ? GRANT_B : GRANT_A;
                            sel   <= (state == GRANT_A);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed and randomized bench for mux2_stream_arbiter: per-scenario tasks with inline checks,
// plus a negedge monitor that logs delivered beats and watches ready exclusivity and burst length.
module tb_mux2_stream_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid, a_last, b_last;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready;
    logic              out_valid, out_last, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sel, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_stream_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    // Beat log filled by the monitor: source (0 = A, 1 = B) and data of each transfer.
    logic              log_src[$];
    logic [DATA_W-1:0] log_data[$];
    logic              a_acc = 1'b0;
    logic              b_acc = 1'b0;
    int                run_len = 0;
    logic              run_active = 1'b0;
    logic              run_sel = 1'b0;

    // Inputs only change 1 ns after a rising edge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        a_acc = a_valid & a_ready;
        b_acc = b_valid & b_ready;
        checks++;
        if (a_ready && b_ready) begin
            errors++;
            $display("FAIL ready_exclusive t=%0t: a_ready=%b b_ready=%b, required not both 1",
                     $time, a_ready, b_ready);
        end
        if (!busy) begin
            run_active = 1'b0;
        end else if (!run_active || sel !== run_sel) begin
            run_active = 1'b1;
            run_sel    = sel;
            run_len    = 0;
        end
        if (out_valid && out_ready) begin
            log_src.push_back(sel);
            log_data.push_back(out_data);
            run_len++;
            checks++;
            if (a_valid && a_ready) begin
                if (out_data !== a_data || out_last !== a_last) begin
                    errors++;
                    $display("FAIL mux_a t=%0t: got data=%h last=%b, required data=%h last=%b",
                             $time, out_data, out_last, a_data, a_last);
                end
            end else if (b_valid && b_ready) begin
                if (out_data !== b_data || out_last !== b_last) begin
                    errors++;
                    $display("FAIL mux_b t=%0t: got data=%h last=%b, required data=%h last=%b",
                             $time, out_data, out_last, b_data, b_last);
                end
            end else begin
                errors++;
                $display("FAIL orphan_beat t=%0t: out beat with no accepted requester (a_ready=%b b_ready=%b)",
                         $time, a_ready, b_ready);
            end
            checks++;
            if (run_len > MAX_BURST) begin
                errors++;
                $display("FAIL burst_len t=%0t: grant carried %0d beats, required at most %0d",
                         $time, run_len, MAX_BURST);
            end
            if (out_last) run_active = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (a_acc) a_data = a_data + 1'b1;
        if (b_acc) b_data = b_data + 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_last    = 1'b0;
        b_last    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_src.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_last    = 1'b1;
        b_last    = 1'b1;
        a_data    = 8'h5A;
        b_data    = 8'hC3;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, sel, a_ready, b_ready, out_valid, out_last} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_ctrl: busy,sel,a_rdy,b_rdy,ovld,olast=%b, required 000000",
                     {busy, sel, a_ready, b_ready, out_valid, out_last});
        end
        checks++;
        if (out_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_data: out_data=%h, required 5a", out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        do_reset();
        a_data    = 8'h11;
        a_valid   = 1'b1;
        a_last    = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b a_ready=%b, required 0 0", busy, a_ready);
        end
        tick();
        checks++;
        if ({busy, sel, a_ready, b_ready, out_valid, out_last} !== 6'b101011 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL single_grant: busy,sel,a_rdy,b_rdy,ovld,olast=%b data=%h, required 101011 11",
                     {busy, sel, a_ready, b_ready, out_valid, out_last}, out_data);
        end
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_release: busy=%b a_ready=%b, required 0 0", busy, a_ready);
        end
        checks++;
        if (log_data.size() != 1 || log_data[0] !== 8'h11) begin
            errors++;
            $display("FAIL single_log: %0d beats logged, required exactly one beat 11", log_data.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q[$];
        do_reset();
        a_valid = 1'b1; a_last = 1'b0; a_data = 8'h40;
        b_valid = 1'b1; b_last = 1'b0; b_data = 8'h50;
        out_ready = 1'b1;
        tick();
        checks++;
        if (sel !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: sel=%b a_ready=%b b_ready=%b, required 0 1 0", sel, a_ready, b_ready);
        end
        tick();
        a_last = 1'b1;
        tick();
        a_valid = 1'b0;
        #1;
        checks++;
        if ({busy, sel, b_ready, a_ready} !== 4'b1110 || out_data !== 8'h50) begin
            errors++;
            $display("FAIL b2b_handoff: busy,sel,b_rdy,a_rdy=%b data=%h, required 1110 50",
                     {busy, sel, b_ready, a_ready}, out_data);
        end
        tick();
        b_last = 1'b1;
        tick();
        b_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b sel=%b, required 0 1", busy, sel);
        end
        exp_q = '{9'h040, 9'h041, 9'h150, 9'h151};
        checks++;
        if (log_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: %0d beats, required %0d", log_data.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if ({log_src[i], log_data[i]} !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h, required %h", i, {log_src[i], log_data[i]}, exp_q[i]);
                end
            end
        end
        // B held the last grant, so A must win the next contention.
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        checks++;
        if (sel !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rr: sel=%b a_ready=%b, required 0 1", sel, a_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_max_burst();
        logic [8:0] exp_q[$];
        do_reset();
        a_valid = 1'b1; a_last = 1'b0; a_data = 8'h60;
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'h70;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp_q = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h170, 9'h064, 9'h065, 9'h066, 9'h067};
        checks++;
        if (log_data.size() != exp_q.size()) begin
            errors++;
            $display("FAIL maxb_count: %0d beats, required %0d", log_data.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if ({log_src[i], log_data[i]} !== exp_q[i]) begin
                    errors++;
                    $display("FAIL maxb_order[%0d]: got %h, required %h", i, {log_src[i], log_data[i]}, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        a_valid = 1'b1; a_last = 1'b0; a_data = 8'h30;
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'h90;
        out_ready = 1'b1;
        tick();
        foreach (ready_pat[i]) begin
            out_ready = ready_pat[i];
            #1;
            checks++;
            if (a_ready !== ready_pat[i] || b_ready !== 1'b0 || sel !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: a_ready=%b b_ready=%b sel=%b, required %b 0 0",
                         i, a_ready, b_ready, sel, ready_pat[i]);
            end
            tick();
        end
        checks++;
        if (log_data.size() != 2) begin
            errors++;
            $display("FAIL stall_count: %0d beats, required 2", log_data.size());
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (sel !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: sel=%b a_ready=%b after 3 beats, required 0 1", sel, a_ready);
        end
        tick();
        checks++;
        if (sel !== 1'b1 || b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: sel=%b b_ready=%b a_ready=%b after 4 beats, required 1 1 0",
                     sel, b_ready, a_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        b_valid = 1'b1; b_last = 1'b0; b_data = 8'h70;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (sel !== 1'b1 || out_valid !== 1'b1 || log_data.size() != 2) begin
            errors++;
            $display("FAIL rstmid_pre: sel=%b out_valid=%b beats=%0d, required 1 1 2",
                     sel, out_valid, log_data.size());
        end
        a_valid = 1'b1;
        a_data  = 8'h20;
        rst     = 1'b1;
        #1;
        checks++;
        if ({out_valid, b_ready, a_ready, sel, busy} !== 5'b00000 || out_data !== 8'h20) begin
            errors++;
            $display("FAIL rstmid_async: ovld,b_rdy,a_rdy,sel,busy=%b data=%h, required 00000 20",
                     {out_valid, b_ready, a_ready, sel, busy}, out_data);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (sel !== 1'b0 || a_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rr: sel=%b a_ready=%b busy=%b, required 0 1 1", sel, a_ready, busy);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] a_exp, b_exp, a_start, b_start;
        int                na, nb;
        do_reset();
        a_data  = 8'h00;
        b_data  = 8'h80;
        a_start = a_data;
        b_start = b_data;
        for (int i = 0; i < 10000; i++) begin
            a_valid   = ($urandom_range(3) != 0);
            a_last    = ($urandom_range(3) == 0);
            b_valid   = ($urandom_range(3) != 0);
            b_last    = ($urandom_range(3) == 0);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_exp = a_start;
        b_exp = b_start;
        na = 0;
        nb = 0;
        foreach (log_data[i]) begin
            checks++;
            if (log_src[i] == 1'b0) begin
                if (log_data[i] !== a_exp) begin
                    errors++;
                    $display("FAIL rand_order_a[%0d]: got %h, required %h", i, log_data[i], a_exp);
                end
                a_exp = a_exp + 1'b1;
                na++;
            end else begin
                if (log_data[i] !== b_exp) begin
                    errors++;
                    $display("FAIL rand_order_b[%0d]: got %h, required %h", i, log_data[i], b_exp);
                end
                b_exp = b_exp + 1'b1;
                nb++;
            end
        end
        checks++;
        if (DATA_W'(na) !== DATA_W'(a_data - a_start) || DATA_W'(nb) !== DATA_W'(b_data - b_start)
            || na == 0 || nb == 0) begin
            errors++;
            $display("FAIL rand_count: delivered A=%0d B=%0d, required accepted A=%0d B=%0d (both nonzero)",
                     na, nb, a_data - a_start, b_data - b_start);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_max_burst();
        test_stall();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
